// File: rtl/interface_ov7670_uc.sv
// Capture controller for the OV7670 sampler: waits for a frame, assembles 16-bit pixels
// from byte pulses and stores N_PIXELS quadrant samples, driving the datapath counters.
module interface_ov7670_uc #(
    parameter int N_PIXELS = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       HREF,
    input  logic       transmite_frame,
    input  logic       transmite_byte,
    input  logic       escreve_byte,
    input  logic       fim_coluna_pixel,
    input  logic       fim_coluna_quadrante,
    output logic       byte_estavel,
    output logic       we_byte,
    output logic       zera_linha_pixel,
    output logic       zera_coluna_pixel,
    output logic       conta_linha_pixel,
    output logic       conta_coluna_pixel,
    output logic       zera_linha_quadrante,
    output logic       zera_coluna_quadrante,
    output logic       conta_linha_quadrante,
    output logic       conta_coluna_quadrante,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA_FRAME = 4'd1,
        ZERA         = 4'd2,
        ESPERA_BYTE  = 4'd3,
        CAPTURA_BYTE = 4'd4,
        AVALIA_PIXEL = 4'd5,
        GRAVA        = 4'd6,
        AVANCA       = 4'd7,
        FIM          = 4'd8
    } state_t;

    typedef struct packed {
        logic byte_estavel;
        logic we_byte;
        logic zera_linha_pixel;
        logic zera_coluna_pixel;
        logic conta_linha_pixel;
        logic conta_coluna_pixel;
        logic zera_linha_quadrante;
        logic zera_coluna_quadrante;
        logic conta_linha_quadrante;
        logic conta_coluna_quadrante;
        logic ocupado;
        logic pronto;
    } ctrl_t;

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [3:0] count_q, count_d;
    ctrl_t      ctrl_q, ctrl_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        unique case (state_q)
            INICIAL:      if (iniciar) state_d = ESPERA_FRAME;
            ESPERA_FRAME: if (transmite_frame) state_d = ZERA;
            ZERA: begin
                phase_d = 1'b0;
                count_d = '0;
                state_d = ESPERA_BYTE;
            end
            ESPERA_BYTE: begin
                if (transmite_frame)              state_d = ZERA;
                else if (transmite_byte && HREF)  state_d = CAPTURA_BYTE;
            end
            CAPTURA_BYTE: begin
                phase_d = ~phase_q;
                state_d = phase_q ? AVALIA_PIXEL : ESPERA_BYTE;
            end
            AVALIA_PIXEL: state_d = escreve_byte ? GRAVA : AVANCA;
            GRAVA: begin
                count_d = count_q + 4'd1;
                state_d = AVANCA;
            end
            AVANCA: state_d = (count_q == 4'(N_PIXELS)) ? FIM : ESPERA_BYTE;
            default: state_d = INICIAL;
        endcase
    end

    // Outputs are registered alongside the state, so they are decoded from the state being entered.
    always_comb begin
        ctrl_d         = '0;
        ctrl_d.ocupado = (state_d != INICIAL);
        case (state_d)
            ZERA: begin
                ctrl_d.zera_linha_pixel      = 1'b1;
                ctrl_d.zera_coluna_pixel     = 1'b1;
                ctrl_d.zera_linha_quadrante  = 1'b1;
                ctrl_d.zera_coluna_quadrante = 1'b1;
            end
            CAPTURA_BYTE: ctrl_d.byte_estavel = 1'b1;
            GRAVA: begin
                ctrl_d.we_byte = 1'b1;
                if (fim_coluna_quadrante) begin
                    ctrl_d.zera_coluna_quadrante = 1'b1;
                    ctrl_d.conta_linha_quadrante = 1'b1;
                end else begin
                    ctrl_d.conta_coluna_quadrante = 1'b1;
                end
            end
            AVANCA: begin
                if (fim_coluna_pixel) begin
                    ctrl_d.zera_coluna_pixel = 1'b1;
                    ctrl_d.conta_linha_pixel = 1'b1;
                end else begin
                    ctrl_d.conta_coluna_pixel = 1'b1;
                end
            end
            FIM:     ctrl_d.pronto = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
        if (!reset) begin
            state_q <= INICIAL;
            phase_q <= 1'b0;
            count_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign byte_estavel           = ctrl_q.byte_estavel;
    assign we_byte                = ctrl_q.we_byte;
    assign zera_linha_pixel       = ctrl_q.zera_linha_pixel;
    assign zera_coluna_pixel      = ctrl_q.zera_coluna_pixel;
    assign conta_linha_pixel      = ctrl_q.conta_linha_pixel;
    assign conta_coluna_pixel     = ctrl_q.conta_coluna_pixel;
    assign zera_linha_quadrante   = ctrl_q.zera_linha_quadrante;
    assign zera_coluna_quadrante  = ctrl_q.zera_coluna_quadrante;
    assign conta_linha_quadrante  = ctrl_q.conta_linha_quadrante;
    assign conta_coluna_quadrante = ctrl_q.conta_coluna_quadrante;
    assign ocupado                = ctrl_q.ocupado;
    assign pronto                 = ctrl_q.pronto;
    assign db_estado              = state_q;

endmodule

// File: tb/tb_interface_ov7670_uc.sv
// Scoreboard bench: a transaction-level model predicts every output pulse and its cycle;
// a negedge monitor pops and compares whenever the controller emits any pulse.
module tb_interface_ov7670_uc;

    localparam int COLS     = 4;
    localparam int N_PIXELS = 9;

    localparam logic [10:0] E_BYTE   = 11'h400;
    localparam logic [10:0] E_WE     = 11'h200;
    localparam logic [10:0] E_ZLP    = 11'h100;
    localparam logic [10:0] E_ZCP    = 11'h080;
    localparam logic [10:0] E_CLP    = 11'h040;
    localparam logic [10:0] E_CCP    = 11'h020;
    localparam logic [10:0] E_ZLQ    = 11'h010;
    localparam logic [10:0] E_ZCQ    = 11'h008;
    localparam logic [10:0] E_CLQ    = 11'h004;
    localparam logic [10:0] E_CCQ    = 11'h002;
    localparam logic [10:0] E_PRONTO = 11'h001;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, HREF = 1'b0, transmite_frame = 1'b0, transmite_byte = 1'b0;
    logic escreve_byte = 1'b0, fim_coluna_pixel = 1'b0, fim_coluna_quadrante = 1'b0;
    logic byte_estavel, we_byte, zera_linha_pixel, zera_coluna_pixel;
    logic conta_linha_pixel, conta_coluna_pixel, zera_linha_quadrante, zera_coluna_quadrante;
    logic conta_linha_quadrante, conta_coluna_quadrante, ocupado, pronto;
    logic [3:0] db_estado;

    interface_ov7670_uc #(.N_PIXELS(N_PIXELS)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .HREF(HREF),
        .transmite_frame(transmite_frame), .transmite_byte(transmite_byte),
        .escreve_byte(escreve_byte), .fim_coluna_pixel(fim_coluna_pixel),
        .fim_coluna_quadrante(fim_coluna_quadrante),
        .byte_estavel(byte_estavel), .we_byte(we_byte),
        .zera_linha_pixel(zera_linha_pixel), .zera_coluna_pixel(zera_coluna_pixel),
        .conta_linha_pixel(conta_linha_pixel), .conta_coluna_pixel(conta_coluna_pixel),
        .zera_linha_quadrante(zera_linha_quadrante), .zera_coluna_quadrante(zera_coluna_quadrante),
        .conta_linha_quadrante(conta_linha_quadrante), .conta_coluna_quadrante(conta_coluna_quadrante),
        .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; logic [10:0] vec; } ev_t;
    ev_t exp_q[$];

    typedef enum { M_IDLE, M_WAIT, M_CAPT } mode_t;
    mode_t m_mode;
    bit    m_phase;
    int    m_stored, m_qcol, m_pcol;

    int n_checks = 0, n_errors = 0, we_seen = 0, pronto_seen = 0;

    function automatic logic [10:0] pulses();
        return {byte_estavel, we_byte, zera_linha_pixel, zera_coluna_pixel, conta_linha_pixel,
                conta_coluna_pixel, zera_linha_quadrante, zera_coluna_quadrante,
                conta_linha_quadrante, conta_coluna_quadrante, pronto};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        logic [10:0] v;
        ev_t e;
        v = pulses();
        if (v != '0) begin
            if (we_byte) we_seen++;
            if (pronto)  pronto_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got %h at cycle %0d, expected none", v, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_vector", 32'(v), 32'(e.vec));
            end
        end
    end

    function automatic void push(input int c, input logic [10:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_phase = 0; m_stored = 0; m_qcol = 0; m_pcol = 0;
    endfunction

    function automatic void model_zera(input int n);
        push(n + 1, E_ZLP | E_ZCP | E_ZLQ | E_ZCQ);
        m_mode = M_CAPT; m_phase = 0; m_stored = 0; m_qcol = 0; m_pcol = 0;
    endfunction

    // Apply one input event for one cycle, predict its consequences, then idle for gap-1 cycles.
    task automatic drive(input bit ini, input bit tf, input bit tb, input bit href,
                         input bit esc, input int gap);
        int n, t;
        n = cyc;
        iniciar = ini; transmite_frame = tf; transmite_byte = tb; HREF = href; escreve_byte = esc;
        fim_coluna_quadrante = (m_qcol == 2);
        fim_coluna_pixel     = (m_pcol == COLS - 1);
        case (m_mode)
            M_IDLE: if (ini) m_mode = M_WAIT;
            M_WAIT: if (tf) model_zera(n);
            M_CAPT: begin
                if (tf) model_zera(n);
                else if (tb && href) begin
                    push(n + 1, E_BYTE);
                    if (!m_phase) m_phase = 1;
                    else begin
                        m_phase = 0;
                        t = n + 3;
                        if (esc) begin
                            push(t, E_WE | ((m_qcol == 2) ? (E_ZCQ | E_CLQ) : E_CCQ));
                            m_qcol = (m_qcol == 2) ? 0 : m_qcol + 1;
                            m_stored++;
                            t++;
                        end
                        push(t, (m_pcol == COLS - 1) ? (E_ZCP | E_CLP) : E_CCP);
                        m_pcol = (m_pcol == COLS - 1) ? 0 : m_pcol + 1;
                        if (m_stored == N_PIXELS) begin
                            push(t + 1, E_PRONTO);
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            default: ;
        endcase
        @(posedge clock); #1;
        iniciar = 0; transmite_frame = 0; transmite_byte = 0;
        repeat (gap - 1) begin @(posedge clock); #1; end
    endtask

    task automatic send_pixel(input bit esc);
        drive(0, 0, 1, 1, 0, 6);
        drive(0, 0, 1, 1, esc, 6);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int we0, pr0;
        model_reset();
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_db_estado", db_estado, 0);
        check("reset_outputs", {pulses(), ocupado}, 0);
        reset = 1;

        // Nominal capture: store every second pixel.
        drive(1, 0, 0, 0, 0, 2);
        check("iniciar_state", db_estado, 1);
        check("iniciar_ocupado", ocupado, 1);
        drive(1, 0, 0, 0, 0, 1);
        check("iniciar_ignored_busy", db_estado, 1);
        drive(0, 1, 0, 0, 0, 6);
        we0 = we_seen;
        pr0 = pronto_seen;
        for (int p = 0; p < 18; p++) send_pixel(p % 2 == 1);
        check("nominal_we_count", we_seen - we0, 9);
        check("nominal_pronto_count", pronto_seen - pr0, 1);
        check("nominal_back_idle", db_estado, 0);
        check("nominal_not_busy", ocupado, 0);

        // HREF gating.
        drive(1, 0, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 6);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 6);
        check("href_gating_state", db_estado, 3);

        // Quadrant wrap on the third store, line wrap on the fourth pixel.
        for (int p = 0; p < 4; p++) send_pixel(1);

        // Frame restart coincident with a byte pulse after 4 stores.
        drive(0, 1, 1, 1, 0, 1);
        check("restart_state", db_estado, 2);
        check("restart_zera", {zera_linha_pixel, zera_coluna_pixel,
                               zera_linha_quadrante, zera_coluna_quadrante}, 4'hf);
        check("restart_no_byte", byte_estavel, 0);
        repeat (5) begin @(posedge clock); #1; end
        pr0 = pronto_seen;
        for (int p = 0; p < 9; p++) send_pixel(1);
        check("restart_full_capture", pronto_seen - pr0, 1);
        check("restart_idle", db_estado, 0);

        // Reset while evaluating a pixel.
        drive(1, 0, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 6);
        drive(0, 0, 1, 1, 0, 6);
        drive(0, 0, 1, 1, 1, 2);
        check("midop_state", db_estado, 5);
        reset = 0;
        exp_q.delete();
        model_reset();
        @(posedge clock); #1;
        check("midop_reset_state", db_estado, 0);
        check("midop_reset_outputs", {pulses(), ocupado}, 0);
        reset = 1;
        repeat (4) begin @(posedge clock); #1; end
        drive(1, 0, 0, 0, 0, 2);
        check("iniciar_after_reset", db_estado, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit tf;
            tf = (m_mode == M_WAIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
            drive(1'($urandom_range(0, 1)), tf, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 6 + $urandom_range(0, 2));
        end

        repeat (8) begin @(posedge clock); #1; end
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/interface_ov7670_uc.md
INTERFACE_OV7670_UC -- requirements
Module: interface_ov7670_uc

Interface
REQ-001 The block SHALL have one parameter: N_PIXELS, default 9, the number of stored pixels per capture (3x3 quadrant samples).
REQ-002 The block SHALL have these ports, one per line:
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-low reset.
- iniciar  input  1  capture request, level-sampled.
- HREF  input  1  camera line-valid, already synchronized to clock.
- transmite_frame  input  1  one-cycle pulse at VSYNC falling edge.
- transmite_byte  input  1  one-cycle pulse at PCLK rising edge.
- escreve_byte  input  1  current pixel row/column matches a sample point.
- fim_coluna_pixel  input  1  pixel column counter at COLUMNS-1.
- fim_coluna_quadrante  input  1  quadrant column counter at 2.
- byte_estavel  output  1  shift the camera byte into the pixel register.
- we_byte  output  1  RAM write enable.
- zera_linha_pixel, zera_coluna_pixel  output  1 each  clear pixel counters.
- conta_linha_pixel, conta_coluna_pixel  output  1 each  advance pixel counters.
- zera_linha_quadrante, zera_coluna_quadrante  output  1 each  clear quadrant counters.
- conta_linha_quadrante, conta_coluna_quadrante  output  1 each  advance quadrant counters.
- ocupado  output  1  high in every state except inicial.
- pronto  output  1  one-cycle pulse at capture completion.
- db_estado  output  4  current state code, for debug.

Function
REQ-003 All control outputs SHALL be Moore outputs decoded from the registered state and registered flags; each SHALL be asserted for exactly one cycle per occurrence.
REQ-004 States and codes SHALL be: inicial 0, espera_frame 1, zera 2, espera_byte 3, captura_byte 4, avalia_pixel 5, grava 6, avanca 7, fim 8. Codes 9-15 SHALL go to inicial.
REQ-005 inicial: iniciar=1 -> espera_frame; otherwise stay.
REQ-006 espera_frame: transmite_frame=1 -> zera; otherwise stay.
REQ-007 zera: assert all four zera_* outputs; clear the byte-phase flag and the stored count; -> espera_byte.
REQ-008 espera_byte: transmite_frame=1 -> zera (retry on the new frame). Otherwise, transmite_byte=1 with HREF=1 -> captura_byte. transmite_byte with HREF=0 SHALL be ignored. transmite_frame SHALL take priority over a simultaneous transmite_byte.
REQ-009 captura_byte: assert byte_estavel and toggle the phase flag. If phase was 0 -> espera_byte; if phase was 1 (second byte of the 16-bit pixel) -> avalia_pixel.
REQ-010 avalia_pixel: escreve_byte=1 -> grava; otherwise -> avanca.
REQ-011 grava: assert we_byte and increment the 4-bit stored count.
- fim_coluna_quadrante=0: assert conta_coluna_quadrante.
- fim_coluna_quadrante=1: assert zera_coluna_quadrante and conta_linha_quadrante.
- Next state: avanca.
REQ-012 avanca:
- fim_coluna_pixel=1: assert zera_coluna_pixel and conta_linha_pixel.
- fim_coluna_pixel=0: assert conta_coluna_pixel.
- Stored count = N_PIXELS -> fim; otherwise -> espera_byte.
REQ-013 fim: assert pronto; -> inicial.
REQ-014 iniciar SHALL be ignored while ocupado=1.
REQ-015 Latency from the second qualifying transmite_byte pulse to we_byte SHALL be 3 cycles (captura_byte, avalia_pixel, grava).
REQ-016 Latency from the we_byte of the N_PIXELS-th store to pronto SHALL be 2 cycles.
REQ-017 transmite_byte pulses that arrive outside espera_byte SHALL be dropped. The datapath guarantees at least 6 clock cycles between PCLK edges.

Reset
REQ-018 With reset=0 at a rising clock edge:
- state SHALL become inicial;
- the phase flag and stored count SHALL clear;
- all outputs SHALL be 0 on the following cycle, except db_estado=0.
REQ-019 Reset asserted in any state, including mid-pixel or grava, SHALL abort the capture without an extra we_byte pulse.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Nominal: iniciar=1, then transmite_frame, then byte pulses with HREF=1 and escreve_byte high on every 2nd pixel -> exactly 9 we_byte pulses, then pronto 2 cycles after the 9th, then db_estado returns to 0.
- HREF gating: 4 transmite_byte pulses with HREF=0 -> no byte_estavel pulse; state stays 3.
- Quadrant wrap: 3 stores -> conta_coluna_quadrante, conta_coluna_quadrante, then zera_coluna_quadrante together with conta_linha_quadrante on the 3rd store (fim_coluna_quadrante=1).
- Line wrap: fim_coluna_pixel=1 in avanca -> zera_coluna_pixel and conta_linha_pixel high in the same cycle; conta_coluna_pixel=0.
- Frame restart: transmite_frame after 4 stores, coincident with a transmite_byte pulse -> state 2, all zera_* outputs high, stored count 0, the byte not captured.
- Reset mid-op: reset=0 in state 5 -> next cycle db_estado=0 and all outputs 0; iniciar is accepted afterwards.
